// File: rtl/cpuhead.sv
// Shared CPU definitions: funct codes seen by the multiply/divide unit and its FSM/kind enums.
package cpuhead;

    typedef logic [5:0] funct_t;

    localparam funct_t FN_MFHI  = 6'h10;
    localparam funct_t FN_MTHI  = 6'h11;
    localparam funct_t FN_MFLO  = 6'h12;
    localparam funct_t FN_MTLO  = 6'h13;
    localparam funct_t FN_MULT  = 6'h18;
    localparam funct_t FN_MULTU = 6'h19;
    localparam funct_t FN_DIV   = 6'h1A;
    localparam funct_t FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    typedef enum logic {
        KIND_MUL = 1'b0,
        KIND_DIV = 1'b1
    } muldiv_kind_t;

    // Magnitude of a 32-bit operand; unsigned operations pass the raw bits through.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring radix-2 divide step.
import cpuhead::*;

module muldiv_iter_step (
    input  muldiv_kind_t kind,
    input  logic [31:0]  acc_hi,
    input  logic [31:0]  acc_lo,
    input  logic [31:0]  operand,
    output logic [31:0]  next_hi,
    output logic [31:0]  next_lo
);

    logic [32:0] sum;
    logic [32:0] rem_sh;
    logic        fits;
    logic [31:0] diff;

    // Multiply keeps {partial product, remaining multiplier bits}; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : 33'd0);
        rem_sh  = {acc_hi, acc_lo[31]};
        fits    = (rem_sh >= {1'b0, operand});
        diff    = rem_sh[31:0] - operand;
        next_hi = acc_hi;
        next_lo = acc_lo;
        if (kind == KIND_MUL) begin
            next_hi = sum[32:1];
            next_lo = {sum[0], acc_lo[31:1]};
        end else begin
            next_hi = fits ? diff : rem_sh[31:0];
            next_lo = {acc_lo[30:0], fits};
        end
    end

endmodule

// File: rtl/hilo_muldiv_seq.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
import cpuhead::*;

module hilo_muldiv_seq #(
    parameter int ITERS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        done,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] LAST_ITER = 6'(ITERS - 1);

    muldiv_state_t state;
    muldiv_kind_t  kind;
    logic [5:0]    iter_cnt;
    logic [31:0]   acc_hi;
    logic [31:0]   acc_lo;
    logic [31:0]   operand;
    logic          neg_result;
    logic          neg_rem;
    logic          div_zero;

    logic          accept;
    logic          op_signed;
    logic          op_div;
    logic [31:0]   abs_a;
    logic [31:0]   abs_b;
    logic [31:0]   step_hi;
    logic [31:0]   step_lo;
    logic [63:0]   product;
    logic [31:0]   fix_hi;
    logic [31:0]   fix_lo;

    assign req_ready = (state == IDLE) && !flush;
    assign busy      = !req_ready;
    assign accept    = req_valid && req_ready;
    assign op_signed = (req_op == FN_MULT) || (req_op == FN_DIV);
    assign op_div    = (req_op == FN_DIV) || (req_op == FN_DIVU);
    assign abs_a     = abs32(req_a, op_signed);
    assign abs_b     = abs32(req_b, op_signed);

    muldiv_iter_step u_step (
        .kind    (kind),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (operand),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    // A zero divisor leaves the remainder equal to |dividend|, so after sign fix-up hi is the raw dividend.
    always_comb begin
        product = {acc_hi, acc_lo};
        fix_hi  = acc_hi;
        fix_lo  = acc_lo;
        if (kind == KIND_MUL) begin
            if (neg_result) begin
                product = ~product + 64'd1;
            end
            fix_hi = product[63:32];
            fix_lo = product[31:0];
        end else begin
            fix_hi = neg_rem ? (~acc_hi + 32'd1) : acc_hi;
            if (div_zero) begin
                fix_lo = 32'hFFFF_FFFF;
            end else if (neg_result) begin
                fix_lo = ~acc_lo + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            kind       <= KIND_MUL;
            iter_cnt   <= 6'd0;
            acc_hi     <= 32'd0;
            acc_lo     <= 32'd0;
            operand    <= 32'd0;
            neg_result <= 1'b0;
            neg_rem    <= 1'b0;
            div_zero   <= 1'b0;
            hi         <= 32'd0;
            lo         <= 32'd0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (req_op)
                            FN_MTHI: hi <= req_a;
                            FN_MTLO: lo <= req_a;
                            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                                kind       <= op_div ? KIND_DIV : KIND_MUL;
                                acc_hi     <= 32'd0;
                                acc_lo     <= op_div ? abs_a : abs_b;
                                operand    <= op_div ? abs_b : abs_a;
                                neg_result <= op_signed && (req_a[31] ^ req_b[31]);
                                neg_rem    <= op_signed && req_a[31];
                                div_zero   <= (req_b == 32'd0);
                                iter_cnt   <= 6'd0;
                                state      <= RUN;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc_hi   <= step_hi;
                        acc_lo   <= step_lo;
                        iter_cnt <= iter_cnt + 6'd1;
                        if (iter_cnt == LAST_ITER) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!flush) begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
